// File: rtl/nandn_pipe.sv
// nandn_pipe: pipelined N_IN-operand bitwise NAND built as a registered GROUP-ary AND tree with valid/ready flow.
// Define NANDN_PARITY_EN to add output nq_par (= ^nq), registered together with nq.
module nandn_pipe #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int GROUP = 2
) (
    input  logic                  ck,
    input  logic                  nrst,
    input  logic [N_IN*WIDTH-1:0] i,
    input  logic                  i_valid,
    output logic                  i_ready,
    output logic [WIDTH-1:0]      nq,
    output logic                  nq_valid,
    input  logic                  nq_ready
`ifdef NANDN_PARITY_EN
    ,
    output logic                  nq_par
`endif
);

    function automatic int calc_levels(input int n, input int g);
        int lv;
        int cap;
        lv  = 1;
        cap = g;
        for (int k = 0; k < 64; k++) begin
            if (cap < n) begin
                cap = cap * g;
                lv  = lv + 1;
            end
        end
        return lv;
    endfunction

    // Entries held by level j: ceil(n / g^(j+1)), computed as repeated ceiling division.
    function automatic int calc_count(input int n, input int g, input int j);
        int c;
        c = n;
        for (int k = 0; k < 64; k++) begin
            if (k <= j) c = (c + g - 1) / g;
        end
        return c;
    endfunction

    localparam int L = calc_levels(N_IN, GROUP);

    generate
        if (N_IN < 1 || N_IN > 64 || GROUP < 2 || GROUP > 8 || WIDTH < 1) begin : g_param_check
            $error("nandn_pipe: WIDTH, N_IN or GROUP out of range");
        end
    endgenerate

    logic [L-1:0] w_v;
    logic [L-1:0] w_adv;

    // A stage advances when it is empty or anything downstream of it can move.
    always_comb begin : p_adv
        logic acc;
        w_adv = '0;
        acc   = nq_ready;
        for (int j = L - 1; j >= 0; j--) begin
            acc      = acc | ~w_v[j];
            w_adv[j] = acc;
        end
    end

    assign i_ready = nrst & w_adv[0];

    genvar gi, gk, gm;
    generate
        for (gi = 0; gi < L; gi++) begin : g_lvl
            localparam int IN_CNT  = (gi == 0) ? N_IN : calc_count(N_IN, GROUP, gi - 1);
            localparam int OUT_CNT = calc_count(N_IN, GROUP, gi);
            localparam bit LAST    = (gi == L - 1);

            logic [IN_CNT*WIDTH-1:0]  w_src;
            logic                     w_src_v;
            logic [OUT_CNT*WIDTH-1:0] w_and;
            logic [OUT_CNT*WIDTH-1:0] r_dat;
            logic                     r_v;

            if (gi == 0) begin : g_src
                assign w_src   = i;
                assign w_src_v = i_valid;
            end else begin : g_src
                assign w_src   = g_lvl[gi-1].r_dat;
                assign w_src_v = g_lvl[gi-1].r_v;
            end

            for (gk = 0; gk < OUT_CNT; gk++) begin : g_grp
                logic [WIDTH-1:0] w_term [GROUP];
                logic [WIDTH-1:0] w_grp;

                // Members past the end of the previous level are padded with all-ones.
                for (gm = 0; gm < GROUP; gm++) begin : g_mem
                    if (gk * GROUP + gm < IN_CNT) begin : g_real
                        assign w_term[gm] = w_src[(gk*GROUP+gm)*WIDTH +: WIDTH];
                    end else begin : g_pad
                        assign w_term[gm] = '1;
                    end
                end

                always_comb begin
                    w_grp = '1;
                    for (int m = 0; m < GROUP; m++) begin
                        w_grp = w_grp & w_term[m];
                    end
                end

                assign w_and[gk*WIDTH +: WIDTH] = w_grp;
            end

            always_ff @(posedge ck or negedge nrst) begin
                if (!nrst) begin
                    r_v   <= 1'b0;
                    r_dat <= '0;
                end else if (w_adv[gi]) begin
                    r_v   <= w_src_v;
                    r_dat <= LAST ? ~w_and : w_and;
                end
            end

            assign w_v[gi] = r_v;
        end
    endgenerate

    assign nq       = g_lvl[L-1].r_dat;
    assign nq_valid = g_lvl[L-1].r_v;

`ifdef NANDN_PARITY_EN
    logic w_par_next;
    logic r_par;

    assign w_par_next = ^(~g_lvl[L-1].w_and);

    always_ff @(posedge ck or negedge nrst) begin
        if (!nrst) begin
            r_par <= 1'b0;
        end else if (w_adv[L-1]) begin
            r_par <= w_par_next;
        end
    end

    assign nq_par = r_par;
`endif

endmodule

// File: tb/tb_nandn_pipe.sv
// Self-checking bench for nandn_pipe: directed vector tables plus randomized traffic against a queue-based NAND model.
// Two instances: N_IN=4/GROUP=2 and N_IN=5/GROUP=3 (non-power fan-in), both WIDTH=8.
`timescale 1ns/1ps
module tb_nandn_pipe;
    localparam int W  = 8;
    localparam int BW = 64 * W;

    logic ck = 1'b0;
    logic nrst;
    always #5 ck = ~ck;

    logic [4*W-1:0] a_i;
    logic           a_iv, a_ir, a_nqv, a_nqr;
    logic [W-1:0]   a_nq;
    logic [5*W-1:0] b_i;
    logic           b_iv, b_ir, b_nqv, b_nqr;
    logic [W-1:0]   b_nq;
`ifdef NANDN_PARITY_EN
    logic           a_par, b_par;
`endif

    nandn_pipe #(.WIDTH(W), .N_IN(4), .GROUP(2)) u_a (
        .ck(ck), .nrst(nrst), .i(a_i), .i_valid(a_iv), .i_ready(a_ir),
        .nq(a_nq), .nq_valid(a_nqv), .nq_ready(a_nqr)
`ifdef NANDN_PARITY_EN
        , .nq_par(a_par)
`endif
    );

    nandn_pipe #(.WIDTH(W), .N_IN(5), .GROUP(3)) u_b (
        .ck(ck), .nrst(nrst), .i(b_i), .i_valid(b_iv), .i_ready(b_ir),
        .nq(b_nq), .nq_valid(b_nqv), .nq_ready(b_nqr)
`ifdef NANDN_PARITY_EN
        , .nq_par(b_par)
`endif
    );

    typedef struct {
        logic [4*W-1:0] in;
        logic [W-1:0]   exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] qa[$];
    logic [W-1:0] qb[$];
    int           pops_a = 0;
    int           pops_b = 0;
    logic         hold_a = 1'b0, hold_b = 1'b0;
    logic [W-1:0] held_a, held_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference: NAND of the first n operands, plain loop over the bundle.
    function automatic logic [W-1:0] ref_nand(input logic [BW-1:0] bus, input int n);
        logic [W-1:0] acc;
        acc = '1;
        for (int k = 0; k < n; k++) acc = acc & bus[k*W +: W];
        return ~acc;
    endfunction

    function automatic logic [4*W-1:0] pack4(input logic [W-1:0] o0, input logic [W-1:0] o1,
                                             input logic [W-1:0] o2, input logic [W-1:0] o3);
        return {o3, o2, o1, o0};
    endfunction

    function automatic logic [W-1:0] rand_byte();
        logic [W-1:0] r;
        r = W'($urandom);
        return ($urandom_range(0, 1) == 1) ? r : 8'hFF;
    endfunction

    task automatic flush_model();
        qa.delete();
        qb.delete();
        hold_a = 1'b0;
        hold_b = 1'b0;
    endtask

    // Called with inputs settled, just before the active edge: applies both handshakes to the model.
    task automatic observe();
        logic [W-1:0] e;
        if (!nrst) begin
            flush_model();
            return;
        end
        if (hold_a) begin
            check("a_hold_valid", a_nqv, 1);
            check("a_hold_data", a_nq, held_a);
        end
        if (a_nqv && a_nqr) begin
            if (qa.size() == 0) check("a_spurious_valid", a_nqv, 0);
            else begin
                e = qa.pop_front();
                check("a_result", a_nq, e);
`ifdef NANDN_PARITY_EN
                check("a_parity", a_par, ^e);
`endif
                pops_a++;
                $display("a: result %h expected %h", a_nq, e);
            end
        end
        hold_a = a_nqv && !a_nqr;
        held_a = a_nq;
        if (a_iv && a_ir) qa.push_back(ref_nand(BW'(a_i), 4));

        if (hold_b) begin
            check("b_hold_valid", b_nqv, 1);
            check("b_hold_data", b_nq, held_b);
        end
        if (b_nqv && b_nqr) begin
            if (qb.size() == 0) check("b_spurious_valid", b_nqv, 0);
            else begin
                e = qb.pop_front();
                check("b_result", b_nq, e);
`ifdef NANDN_PARITY_EN
                check("b_parity", b_par, ^e);
`endif
                pops_b++;
                $display("b: result %h expected %h", b_nq, e);
            end
        end
        hold_b = b_nqv && !b_nqr;
        held_b = b_nq;
        if (b_iv && b_ir) qb.push_back(ref_nand(BW'(b_i), 5));
    endtask

    task automatic tick();
        #1;
        observe();
        @(posedge ck);
        @(negedge ck);
    endtask

    vec_t         tbl [4];
    logic [4*W-1:0] bp_in [6];

    initial begin
        int idx;
        int p0;
        logic acc;
        logic a_keep, b_keep;

        tbl[0] = '{pack4(8'hFF, 8'hFF, 8'hFF, 8'hFF), 8'h00};
        tbl[1] = '{pack4(8'hF0, 8'hFF, 8'hFF, 8'hFF), 8'h0F};
        tbl[2] = '{pack4(8'hAA, 8'h55, 8'hFF, 8'hFF), 8'hFF};
        tbl[3] = '{pack4(8'h81, 8'hC3, 8'hE7, 8'hFF), 8'h7E};
        for (int k = 0; k < 6; k++) bp_in[k] = {rand_byte(), rand_byte(), rand_byte(), rand_byte()};

        nrst  = 1'b1;
        a_iv  = 1'b0; a_nqr = 1'b1; a_i = '1;
        b_iv  = 1'b0; b_nqr = 1'b1; b_i = '1;
        #2 nrst = 1'b0;
        @(negedge ck);

        // Reset: valid input is ignored while nrst is low
        a_iv = 1'b1;
        a_i  = tbl[0].in;
        repeat (3) tick();
        check("rst_nq", a_nq, 8'h00);
        check("rst_nq_valid", a_nqv, 0);
        check("rst_b_nq_valid", b_nqv, 0);
`ifdef NANDN_PARITY_EN
        check("rst_par", a_par, 0);
`endif

        nrst = 1'b1;
        tick();
        a_iv = 1'b0;
        tick();
        check("release_nq_valid", a_nqv, 1);
        check("release_nq", a_nq, 8'h00);
        tick();

        // Streaming table, two-cycle latency, one result per cycle
        for (int s = 0; s < 6; s++) begin
            a_iv = (s < 4);
            if (s < 4) a_i = tbl[s].in;
            if (s >= 2) begin
                check("stream_nq_valid", a_nqv, 1);
                check("stream_nq", a_nq, tbl[s-2].exp);
            end else begin
                check("stream_idle_valid", a_nqv, 0);
            end
            tick();
        end

        // Backpressure: nq_ready low for 5 cycles while streaming
        idx = 0;
        p0  = pops_a;
        for (int s = 0; s < 40 && (idx < 6 || qa.size() != 0); s++) begin
            a_nqr = (s >= 5);
            a_iv  = (idx < 6);
            if (idx < 6) a_i = bp_in[idx];
            #1;
            acc = a_iv & a_ir;
            if (s < 2) check("bp_ready_high", a_ir, 1);
            else if (s < 5) begin
                check("bp_ready_low", a_ir, 0);
                check("bp_hold_first", a_nq, ref_nand(BW'(bp_in[0]), 4));
            end
            tick();
            if (acc) idx++;
        end
        a_iv  = 1'b0;
        a_nqr = 1'b1;
        check("bp_result_count", pops_a - p0, 6);

        // Bubble collapse: an empty first stage keeps accepting while the output is blocked
        p0    = pops_a;
        a_nqr = 1'b0;
        a_iv  = 1'b1;
        a_i   = pack4(8'h3C, 8'hFF, 8'hFF, 8'hFF);
        tick();
        a_iv = 1'b0;
        for (int s = 0; s < 3; s++) begin
            #1 check("bubble_idle_ready", a_ir, 1);
            tick();
        end
        a_iv = 1'b1;
        a_i  = pack4(8'hFF, 8'h0F, 8'hF7, 8'hFF);
        #1 check("bubble_second_ready", a_ir, 1);
        tick();
        a_iv  = 1'b0;
        a_nqr = 1'b1;
        repeat (4) tick();
        check("bubble_result_count", pops_a - p0, 2);

        // Non-power fan-in: padding must not force any bit
        b_iv = 1'b1;
        b_i  = {8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tick();
        b_i = {8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF};
        tick();
        b_iv = 1'b0;
        check("b_nq_valid", b_nqv, 1);
        check("b_nq_fe", b_nq, 8'h01);
        tick();
        check("b_nq_00", b_nq, 8'hFF);
        tick();

        // Mid-flight reset with two bundles held in the pipe
        a_nqr = 1'b0;
        a_iv  = 1'b1;
        a_i   = pack4(8'h12, 8'hFF, 8'hFF, 8'hFF);
        tick();
        a_i = pack4(8'h34, 8'hFF, 8'hFF, 8'hFF);
        tick();
        a_iv = 1'b0;
        check("mrst_pre_valid", a_nqv, 1);
        #1 nrst = 1'b0;
        #1 check("mrst_valid_drop", a_nqv, 0);
        #1 nrst = 1'b1;
        flush_model();
        @(negedge ck);
        a_nqr = 1'b1;
        for (int s = 0; s < 3; s++) begin
            check("mrst_no_stale", a_nqv, 0);
            tick();
        end
        a_iv = 1'b1;
        a_i  = pack4(8'h0F, 8'hFF, 8'hFF, 8'hFF);
        tick();
        a_iv = 1'b0;
        tick();
        check("mrst_after_valid", a_nqv, 1);
        check("mrst_after_nq", a_nq, 8'hF0);
`ifdef NANDN_PARITY_EN
        check("mrst_after_par", a_par, 0);
`endif
        tick();

        // Randomized traffic on both instances; sources hold a refused bundle
        a_keep = 1'b0;
        b_keep = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!a_keep) begin
                a_iv = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < 4; k++) a_i[k*W +: W] = rand_byte();
            end
            if (!b_keep) begin
                b_iv = ($urandom_range(0, 3) != 0);
                for (int k = 0; k < 5; k++) b_i[k*W +: W] = rand_byte();
            end
            a_nqr = ($urandom_range(0, 2) != 0);
            b_nqr = ($urandom_range(0, 2) != 0);
            #1;
            a_keep = a_iv & ~a_ir;
            b_keep = b_iv & ~b_ir;
            tick();
        end
        a_iv  = 1'b0; b_iv  = 1'b0;
        a_nqr = 1'b1; b_nqr = 1'b1;
        for (int c = 0; c < 20 && (qa.size() != 0 || qb.size() != 0); c++) tick();
        check("a_drain_empty", qa.size(), 0);
        check("b_drain_empty", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nandn_pipe.md
Name: nandn_pipe

Overview:
- Parametrised, pipelined N-input bitwise NAND.
- Generalises the 2-input nand2 cell in three ways: operand count N_IN, lane width WIDTH, and reduction-tree fan-in GROUP.
- Each tree level is registered and the pipeline has elastic valid/ready flow control.
- Used as a wide-gate building block in datapath and test structures where a single-cycle wide NAND would not close timing.

Parameters:
- WIDTH, 8: bits per operand and per result lane.
- N_IN, 4: number of operands; legal range 1..64.
- GROUP, 2: fan-in per tree level; legal range 2..8.

Ports:
- ck  input  1  clock; all state updates on its rising edge.
- nrst  input  1  asynchronous, active-low reset.
- i  input  N_IN*WIDTH  operands; operand k occupies bits [k*WIDTH +: WIDTH].
- i_valid  input  1  operand bundle valid.
- i_ready  output  1  pipeline accepts a bundle this cycle.
- nq  output  WIDTH  result, ~(i0 & i1 & ... & i(N_IN-1)) per bit.
- nq_valid  output  1  nq holds a valid result.
- nq_ready  input  1  downstream accepts nq this cycle.

Behaviour:
- Levels: L = ceil(log_GROUP(N_IN)), minimum 1.
  - Level j holds ceil(N_IN/GROUP^(j+1)) partial ANDs, each WIDTH bits, plus one valid bit v[j].
  - Missing group members are padded with all-ones (AND identity).
  - Level j ANDs GROUP consecutive entries from level j-1. Level 0 takes its entries from i.
  - The last level registers the inverted AND, and that register drives nq.
- N_IN=1: L=1; nq is a registered ~i0.
- Reset (nrst low, asynchronous): all v[j]=0, nq=0, all partial registers=0. i_ready goes high combinationally once nrst is high. Release of reset is synchronous to ck via the normal register path.
- Latency: L cycles from the accepting edge (i_valid & i_ready) to nq_valid=1, with no backpressure.
- Throughput: 1 bundle per cycle while nq_ready=1.
- Stage advance rule:
  - adv[L-1] = v[L-1]==0 | nq_ready.
  - adv[j] = v[j]==0 | adv[j+1].
  - i_ready = adv[0].
  - The ready chain is combinational, so bubbles collapse: an empty stage always accepts.
- On adv[j]:
  - Level j data loads from level j-1, or from i for j=0.
  - v[j] loads v[j-1], or i_valid for j=0.
- Without adv[j], level j holds data and valid unchanged.
- Holding rules:
  - nq and nq_valid hold stable while nq_valid=1 and nq_ready=0 (AXI-style).
  - Data is not required to change when valid=0, but must not be X after reset.
- i_valid=1 while i_ready=0: the bundle is not taken. The source must hold it.
- Simultaneous accept at input and output with a full pipeline: both occur in the same cycle and the occupancy count is unchanged.
- Reset asserted mid-operation: all in-flight bundles are discarded with no partial output; nq_valid drops immediately (asynchronous).
- Out-of-range parameters: compile-time error via a generate-time check.

Optional Feature:
- Macro: NANDN_PARITY_EN.
- Defined:
  - Adds output port nq_par (1 bit) = ^nq (XOR of all nq bits).
  - It is registered at the last level, so it is cycle-aligned with nq and follows the same hold and reset rules (reset value 0).
- Undefined: port nq_par is absent and no extra logic is generated.

Test Plan:
- Reset check: WIDTH=8, N_IN=4, GROUP=2. Hold nrst low and drive i_valid=1 -> nq=0x00, nq_valid=0. Release reset, drive i={0xFF,0xFF,0xFF,0xFF} -> after 2 cycles nq=0x00, nq_valid=1.
- Streaming: present four back-to-back bundles, with nq_ready=1 throughout:
  - {0xFF,0xFF,0xFF,0xFF} -> nq=0x00
  - {0xF0,0xFF,0xFF,0xFF} -> nq=0x0F
  - {0xAA,0x55,0xFF,0xFF} -> nq=0xFF
  - {0x81,0xC3,0xE7,0xFF} -> nq=0x7E
  - Results appear on consecutive cycles starting 2 cycles after the first accept.
- Backpressure: hold nq_ready=0 for 5 cycles while streaming.
  - i_ready falls after 2 accepts.
  - nq stays at the first result.
  - On release, results resume in order with no loss or duplication.
- Bubble collapse: send one bundle, wait 3 idle cycles with nq_ready=0, then send another -> i_ready=1 throughout the idle cycles, and both results appear in order.
- Non-power fan-in: N_IN=5, GROUP=3, so L=2. Drive i={0xFF,0xFF,0xFF,0xFF,0xFE} -> nq=0x01 after 2 cycles. Padding is all-ones, so it must not force any result bit.
- Mid-flight reset plus parity (NANDN_PARITY_EN defined):
  - Pulse nrst low with 2 bundles in flight -> nq_valid=0 immediately, and no stale result appears after release.
  - Then drive i={0x0F,0xFF,0xFF,0xFF} -> nq=0xF0, nq_par=0.
